// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, imem addressing and the IF/ID register.
// Optional zero-penalty j pre-decode is enabled by defining FETCH_EARLY_JUMP_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid
);

    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] pc4_r;
    logic        valid_r;

    logic [31:0] pc_plus4_s;
    logic [31:0] jump_target_s;
    logic [31:0] fetch_target_s;
    logic        jump_req_s;
    logic [31:0] pc_next_s;
    logic [31:0] instr_next_s;
    logic [31:0] pc4_next_s;
    logic        valid_next_s;

`ifdef FETCH_EARLY_JUMP_EN
    logic        pre_jump_s;
    logic        unused_jump_s;

    // Pre-decode j in IF so a fetched jump redirects with no bubble; the ID-side jump port goes idle.
    always_comb begin
        pre_jump_s    = (imem_rdata[31:26] == 6'b000010);
        unused_jump_s = jump;
        jump_req_s    = 1'b0;
        if (pre_jump_s) begin
            fetch_target_s = {pc_plus4_s[31:28], imem_rdata[25:0], 2'b00};
        end else begin
            fetch_target_s = pc_plus4_s;
        end
    end
`else
    // Without pre-decode, jumps arrive only from ID and the fetch path is plain sequential.
    always_comb begin
        jump_req_s     = jump;
        fetch_target_s = pc_plus4_s;
    end
`endif

    // Sequential and redirect addresses; the jump region comes from the j's own PC+4 held in IF/ID.
    always_comb begin
        pc_plus4_s    = pc_r + 32'd4;
        jump_target_s = {pc4_r[31:28], jump_index, 2'b00};
    end

    // Next-state selection: branch > jump > stall > flush > normal fetch.
    always_comb begin
        pc_next_s    = pc_r;
        instr_next_s = instr_r;
        pc4_next_s   = pc4_r;
        valid_next_s = valid_r;
        if (branch_taken) begin
            pc_next_s    = branch_target & 32'hFFFF_FFFC;
            instr_next_s = 32'h0000_0000;
            pc4_next_s   = 32'h0000_0000;
            valid_next_s = 1'b0;
        end else if (jump_req_s) begin
            pc_next_s    = jump_target_s;
            instr_next_s = 32'h0000_0000;
            pc4_next_s   = 32'h0000_0000;
            valid_next_s = 1'b0;
        end else if (stall) begin
            pc_next_s    = pc_r;
            instr_next_s = instr_r;
            pc4_next_s   = pc4_r;
            valid_next_s = valid_r;
        end else if (flush) begin
            pc_next_s    = pc_plus4_s;
            instr_next_s = 32'h0000_0000;
            pc4_next_s   = 32'h0000_0000;
            valid_next_s = 1'b0;
        end else begin
            pc_next_s    = fetch_target_s;
            instr_next_s = imem_rdata;
            pc4_next_s   = pc_plus4_s;
            valid_next_s = 1'b1;
        end
    end

    // PC and IF/ID registers; reset wins over every other request on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r    <= RESET_PC & 32'hFFFF_FFFC;
            instr_r <= 32'h0000_0000;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else begin
            pc_r    <= pc_next_s;
            instr_r <= instr_next_s;
            pc4_r   <= pc4_next_s;
            valid_r <= valid_next_s;
        end
    end

    assign imem_addr   = pc_r[IMEM_AW+1:2];
    assign pc          = pc_r;
    assign if_id_instr = instr_r;
    assign if_id_pc4   = pc4_r;
    assign if_id_valid = valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF results are queued as each step is driven
// and popped for comparison one edge later.
module tb_fetch_stage;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          flush;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic          jump;
    logic [25:0]   jump_index;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   pc;
    logic [31:0]   if_id_instr;
    logic [31:0]   if_id_pc4;
    logic          if_id_valid;

    logic [31:0]   imem [0:255];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr];

    fetch_stage #(.RESET_PC(32'h0000_0040), .IMEM_AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expected result, then compare after the edge.
    task automatic step(input string tag,
                        input logic r, input logic s, input logic f,
                        input logic b, input logic [31:0] tgt,
                        input logic j, input logic [25:0] idx,
                        input logic [31:0] epc, input logic [31:0] ei,
                        input logic [31:0] ep4, input logic ev);
        exp_t e;
        reset         = r;
        stall         = s;
        flush         = f;
        branch_taken  = b;
        branch_target = tgt;
        jump          = j;
        jump_index    = idx;
        e.pc    = epc;
        e.instr = ei;
        e.pc4   = ep4;
        e.valid = ev;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".pc"},    pc,          e.pc);
        chk({tag, ".instr"}, if_id_instr, e.instr);
        chk({tag, ".pc4"},   if_id_pc4,   e.pc4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
    endtask

    task automatic chk_addr(input string tag, input logic [AW-1:0] exp);
        chk(tag, {24'd0, imem_addr}, {24'd0, exp});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'h8C00_0000 | 32'(i);
        end
        imem[16] = 32'h8C22_0004;

        // Reset state
        step("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0000_0040, 32'h0, 32'h0, 1'b0);
        step("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0000_0040, 32'h0, 32'h0, 1'b0);
        chk_addr("rst.addr", 8'h10);

        // First fetch from RESET_PC
        step("fetch40", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0000_0044, 32'h8C22_0004, 32'h0000_0044, 1'b1);

        // Redirect to 0, then straight-line fetch
        step("br0", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 26'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step("seq0", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h4, 32'h8C00_0000, 32'h4, 1'b1);
        step("seq1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h8, 32'h8C00_0001, 32'h8, 1'b1);

        // Two-cycle stall at pc=0x08; flush in the second cycle is ignored
        step("stall0", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h8, 32'h8C00_0001, 32'h8, 1'b1);
        step("stall1", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 32'h8, 32'h8C00_0001, 32'h8, 1'b1);
        step("seq2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'hC, 32'h8C00_0002, 32'hC, 1'b1);
        step("seq3", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h10, 32'h8C00_0003, 32'h10, 1'b1);

        // Flush: PC still advances, IF/ID becomes a bubble
        step("flush", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 32'h14, 32'h0, 32'h0, 1'b0);
        step("seq5", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h18, 32'h8C00_0005, 32'h18, 1'b1);

        // Branch beats stall, jump and flush; target low bits cleared
        step("brall", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b1, 26'h3FF_FFFF, 32'h0000_0100, 32'h0, 32'h0, 1'b0);

        // Set up if_id_pc4=0x1000_0008, then a jump with stall
        step("brhi", 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0004, 1'b0, 26'h0, 32'h1000_0004, 32'h0, 32'h0, 1'b0);
        step("seqhi", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h1000_0008, 32'h8C00_0001, 32'h1000_0008, 1'b1);
`ifdef FETCH_EARLY_JUMP_EN
        step("jmpign", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h10, 32'h1000_0008, 32'h8C00_0001, 32'h1000_0008, 1'b1);
`else
        step("jump", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h10, 32'h1000_0040, 32'h0, 32'h0, 1'b0);
`endif

        // PC wrap at the top of the address space, imem_addr wraps too
        step("brtop", 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        chk_addr("top.addr", 8'hFF);
        step("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0, 32'h8C00_00FF, 32'h0, 1'b1);
        chk_addr("wrap.addr", 8'h00);

        // A j fetched at 0x0
        imem[0] = 32'h0800_0010;
`ifdef FETCH_EARLY_JUMP_EN
        step("earlyj", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h40, 32'h0800_0010, 32'h4, 1'b1);
`else
        step("jfetch", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h4, 32'h0800_0010, 32'h4, 1'b1);
`endif

        // Mid-operation reset overrides a simultaneous branch
        step("midrst", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 26'h0, 32'h0000_0040, 32'h0, 32'h0, 1'b0);
        step("refetch", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0000_0044, 32'h8C22_0004, 32'h0000_0044, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
